// File: rtl/smcore_pkg.sv
// Shared widths, opcode/state encodings and instruction field helpers for sm_core.
package smcore_pkg;
   localparam int SM_N_LANES = 4;
   localparam int SM_DATA_W  = 16;
   localparam int SM_INST_W  = 24;
   localparam int SM_IADDR_W = 8;
   localparam int SM_DADDR_W = 8;

   typedef enum logic [3:0] {
      OP_NOP = 4'h0, OP_LDI = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
      OP_AND = 4'h4, OP_OR  = 4'h5, OP_LD  = 4'h6, OP_ST  = 4'h7,
      OP_XOR = 4'h8, OP_MUL = 4'h9, OP_END = 4'hF
   } op_e;

   typedef enum logic [4:0] {
      S_FETCH = 5'd0, S_DECODE = 5'd1, S_EXEC = 5'd2,
      S_MEM_ADDR = 5'd3, S_MEM_WAIT = 5'd4, S_END = 5'd19
   } state_e;

   function automatic logic [3:0] f_op(input logic [SM_INST_W-1:0] i);
      return i[23:20];
   endfunction
   function automatic logic [3:0] f_rd(input logic [SM_INST_W-1:0] i);
      return i[19:16];
   endfunction
   function automatic logic [3:0] f_ra(input logic [SM_INST_W-1:0] i);
      return i[15:12];
   endfunction
   function automatic logic [3:0] f_rb(input logic [SM_INST_W-1:0] i);
      return i[11:8];
   endfunction
   function automatic logic [7:0] f_imm(input logic [SM_INST_W-1:0] i);
      return i[7:0];
   endfunction
endpackage

// File: rtl/sm_core_if.sv
// Instruction and data memory bus of sm_core; master is the core side.
interface sm_core_if #(
   parameter int DATA_W  = 16,
   parameter int INST_W  = 24,
   parameter int IADDR_W = 8,
   parameter int DADDR_W = 8
);
   logic [IADDR_W-1:0] inst_addr;
   logic [INST_W-1:0]  inst;
   logic [DADDR_W-1:0] DataAddress;
   logic [DATA_W-1:0]  DataToWrite;
   logic [DATA_W-1:0]  DataToRead;
   logic               DataMemWrEn;

   modport master (output inst_addr, DataAddress, DataToWrite, DataMemWrEn,
                   input  inst, DataToRead);
   modport slave  (input  inst_addr, DataAddress, DataToWrite, DataMemWrEn,
                   output inst, DataToRead);
endinterface

// File: rtl/sp_lane.sv
// One scalar lane: 16-entry register file (R0 = 0, R15 = lane index) plus ALU.
// SMCORE_MUL_EN adds the MUL opcode; without it opcode 9 is a NOP.
module sp_lane import smcore_pkg::*; #(
   parameter int LANE_IDX = 0,
   parameter int DATA_W   = SM_DATA_W,
   parameter int DADDR_W  = SM_DADDR_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               alu_we,
   input  logic               ld_we,
   input  op_e                op,
   input  logic [3:0]         rd,
   input  logic [3:0]         ra,
   input  logic [3:0]         rb,
   input  logic [7:0]         imm,
   input  logic [DATA_W-1:0]  ld_data,
   output logic [DADDR_W-1:0] addr,
   output logic [DATA_W-1:0]  st_data
);
   logic [DATA_W-1:0] rf [16];
   logic [DATA_W-1:0] va, vb, res;
   logic              wr;

   always_comb begin
      va = (ra == 4'd0) ? '0 : (ra == 4'd15) ? DATA_W'(LANE_IDX) : rf[ra];
      vb = (rb == 4'd0) ? '0 : (rb == 4'd15) ? DATA_W'(LANE_IDX) : rf[rb];
   end

   assign addr    = DADDR_W'(va + DATA_W'(imm));
   assign st_data = vb;

   always_comb begin
      res = '0;
      wr  = 1'b1;
      case (op)
         OP_LDI:  res = DATA_W'(imm);
         OP_ADD:  res = va + vb;
         OP_SUB:  res = va - vb;
         OP_AND:  res = va & vb;
         OP_OR:   res = va | vb;
         OP_XOR:  res = va ^ vb;
`ifdef SMCORE_MUL_EN
         OP_MUL:  res = va * vb;
`endif
         default: wr = 1'b0;
      endcase
   end

   // R0 and R15 are hardwired on the read side, so their storage is never written
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 16; i++) rf[i] <= '0;
      end else if (rd != 4'd0 && rd != 4'd15) begin
         if (ld_we)             rf[rd] <= ld_data;
         else if (alu_we && wr) rf[rd] <= res;
      end
   end
endmodule

// File: rtl/sm_core.sv
// Single-issue SIMT core: one control FSM drives N_LANES sp_lane instances in
// lockstep; lane loads/stores are serialized onto the single data port.
// Optional MUL opcode under SMCORE_MUL_EN (handled inside sp_lane).
module sm_core import smcore_pkg::*; #(
   parameter int N_LANES = SM_N_LANES,
   parameter int DATA_W  = SM_DATA_W,
   parameter int INST_W  = SM_INST_W,
   parameter int IADDR_W = SM_IADDR_W,
   parameter int DADDR_W = SM_DADDR_W
) (
   input logic       clk,
   input logic       reset,
   sm_core_if.master bus
);
   localparam int LW = (N_LANES > 1) ? $clog2(N_LANES) : 1;

   state_e             state;
   logic [IADDR_W-1:0] pc;
   logic [INST_W-1:0]  ir;
   logic [LW-1:0]      lane_cnt;
   op_e                op;
   logic               last;

   logic [N_LANES-1:0][DADDR_W-1:0] lane_addr;
   logic [N_LANES-1:0][DATA_W-1:0]  lane_rb;

   assign op   = op_e'(f_op(ir));
   assign last = (lane_cnt == LW'(N_LANES - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_FETCH;
         pc       <= '0;
         ir       <= '0;
         lane_cnt <= '0;
      end else begin
         case (state)
            S_FETCH:  state <= S_DECODE;
            S_DECODE: begin
               ir       <= bus.inst;
               lane_cnt <= '0;
               case (op_e'(f_op(bus.inst)))
                  OP_END:       state <= S_END;
                  OP_LD, OP_ST: state <= S_MEM_ADDR;
                  default:      state <= S_EXEC;
               endcase
            end
            S_EXEC: begin
               pc    <= pc + IADDR_W'(1);
               state <= S_FETCH;
            end
            S_MEM_ADDR: begin
               if (op == OP_LD) begin
                  state <= S_MEM_WAIT;
               end else if (last) begin
                  pc    <= pc + IADDR_W'(1);
                  state <= S_FETCH;
               end else begin
                  lane_cnt <= lane_cnt + LW'(1);
               end
            end
            S_MEM_WAIT: begin
               if (last) begin
                  pc    <= pc + IADDR_W'(1);
                  state <= S_FETCH;
               end else begin
                  lane_cnt <= lane_cnt + LW'(1);
                  state    <= S_MEM_ADDR;
               end
            end
            S_END:   state <= S_END;
            default: state <= S_FETCH;
         endcase
      end
   end

   // Bus outputs decode straight from registers so reset forces them low at once
   assign bus.inst_addr   = pc;
   assign bus.DataMemWrEn = (state == S_MEM_ADDR) && (op == OP_ST);
   assign bus.DataAddress = (state == S_MEM_ADDR) ? lane_addr[lane_cnt] : '0;
   assign bus.DataToWrite = bus.DataMemWrEn ? lane_rb[lane_cnt] : '0;

   for (genvar g = 0; g < N_LANES; g++) begin : g_lane
      sp_lane #(.LANE_IDX(g), .DATA_W(DATA_W), .DADDR_W(DADDR_W)) u_lane (
         .clk     (clk),
         .reset   (reset),
         .alu_we  (state == S_EXEC),
         .ld_we   ((state == S_MEM_WAIT) && (lane_cnt == LW'(g))),
         .op      (op),
         .rd      (f_rd(ir)),
         .ra      (f_ra(ir)),
         .rb      (f_rb(ir)),
         .imm     (f_imm(ir)),
         .ld_data (bus.DataToRead),
         .addr    (lane_addr[g]),
         .st_data (lane_rb[g])
      );
   end
endmodule

// File: tb/tb_sm_core.sv
// Bench for sm_core: ISA-level reference model predicts store traffic, cycle
// count and final data memory; directed programs pin literal results.
module tb_sm_core;
   typedef struct { logic [7:0] a; logic [15:0] d; } wr_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   sm_core_if bus();
   sm_core dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   logic [23:0] imem [256];
   logic [15:0] dmem [256];
   logic [15:0] dmem_init [256];
   logic        mem_load = 1'b0;

   always @(posedge clk) begin
      bus.inst       <= imem[bus.inst_addr];
      bus.DataToRead <= dmem[bus.DataAddress];
      if (mem_load) for (int i = 0; i < 256; i++) dmem[i] <= dmem_init[i];
      else if (bus.DataMemWrEn) dmem[bus.DataAddress] <= bus.DataToWrite;
   end

   logic [23:0] prog [64];
   int          plen;
   logic [15:0] mmem [256];
   logic [15:0] regs [4][16];
   wr_t         exp_wr [$];
   int          exp_cyc;
   int          checks = 0;
   int          errors = 0;
   bit          chk_on = 1'b0;
   int          wr_pulses = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, act, exp);
      end
   endtask

   // every store pulse must match the next store the model predicted
   always @(negedge clk) begin
      if (chk_on && bus.DataMemWrEn === 1'b1) begin
         wr_t w;
         wr_pulses++;
         checks++;
         if (exp_wr.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write addr=%0h data=%0h", bus.DataAddress, bus.DataToWrite);
         end else begin
            w = exp_wr.pop_front();
            if (bus.DataAddress !== w.a || bus.DataToWrite !== w.d) begin
               errors++;
               $display("FAIL store got=%0h:%0h exp=%0h:%0h", bus.DataAddress, bus.DataToWrite, w.a, w.d);
            end
         end
      end
   end

   function automatic logic [23:0] enc(input logic [3:0] op, rd, ra, rb, input logic [7:0] imm);
      return {op, rd, ra, rb, imm};
   endfunction

   task automatic add(input logic [23:0] w);
      prog[plen] = w;
      plen++;
   endtask

   function automatic logic [15:0] rv(input int l, input int r);
      if (r == 0) return 16'h0;
      if (r == 15) return 16'(l);
      return regs[l][r];
   endfunction

   task automatic wreg(input int l, input int r, input logic [15:0] v);
      if (r != 0 && r != 15) regs[l][r] = v;
   endtask

   task automatic model_run();
      int pc = 0;
      logic [23:0] w;
      logic [15:0] a, b, v;
      logic [7:0] ad;
      int op, rd, ra, rb;
      logic [7:0] imm;
      bit alu;
      for (int l = 0; l < 4; l++) for (int r = 0; r < 16; r++) regs[l][r] = 16'h0;
      for (int i = 0; i < 256; i++) mmem[i] = dmem_init[i];
      exp_wr.delete();
      exp_cyc = 2;
      for (int step = 0; step < 1000; step++) begin
         w = (pc < plen) ? prog[pc] : 24'h0;
         op = int'(w[23:20]); rd = int'(w[19:16]); ra = int'(w[15:12]); rb = int'(w[11:8]);
         imm = w[7:0];
         if (op == 15) break;
         exp_cyc += (op == 6) ? 10 : (op == 7) ? 6 : 3;
         for (int l = 0; l < 4; l++) begin
            a = rv(l, ra); b = rv(l, rb);
            ad = 8'(a + {8'h0, imm});
            alu = 1'b1;
            v = 16'h0;
            case (op)
               1: v = {8'h0, imm};
               2: v = a + b;
               3: v = a - b;
               4: v = a & b;
               5: v = a | b;
               8: v = a ^ b;
`ifdef SMCORE_MUL_EN
               9: v = a * b;
`endif
               default: alu = 1'b0;
            endcase
            if (alu) wreg(l, rd, v);
            if (op == 6) wreg(l, rd, mmem[ad]);
            if (op == 7) begin
               mmem[ad] = b;
               exp_wr.push_back('{a: ad, d: b});
            end
         end
         pc = (pc + 1) % 256;
      end
   endtask

   task automatic load_mems();
      reset = 1'b0;
      chk_on = 1'b0;
      for (int i = 0; i < 256; i++) imem[i] = (i < plen) ? prog[i] : 24'h0;
      @(negedge clk);
      mem_load = 1'b1;
      @(posedge clk);
      #1 mem_load = 1'b0;
   endtask

   task automatic run_prog(input bit hold);
      int cyc = 0;
      int mism = 0;
      int bad = 0;
      logic [7:0] a0;
      load_mems();
      model_run();
      @(negedge clk);
      reset = 1'b1;
      wr_pulses = 0;
      chk_on = 1'b1;
      #1;
      check("reset_inst_addr", bus.inst_addr, 0);
      check("reset_wren", bus.DataMemWrEn, 0);
      check("reset_state", dut.state, 0);
      while (int'(dut.state) != 19 && cyc < 2000) begin
         @(posedge clk);
         #1 cyc++;
      end
      check("cycles_to_end", cyc, exp_cyc);
      check("state_end", dut.state, 19);
      check("stores_left", exp_wr.size(), 0);
      for (int i = 0; i < 256; i++) if (dmem[i] !== mmem[i]) mism++;
      check("dmem_vs_model", mism, 0);
      if (hold) begin
         a0 = bus.inst_addr;
         repeat (20) begin
            @(negedge clk);
            if (int'(dut.state) != 19 || bus.inst_addr !== a0 || bus.DataMemWrEn !== 1'b0) bad++;
         end
         check("end_hold", bad, 0);
      end
      chk_on = 1'b0;
   endtask

   task automatic clear_init();
      for (int i = 0; i < 256; i++) dmem_init[i] = 16'h0;
      plen = 0;
   endtask

   initial begin
      int found;
      repeat (3) @(posedge clk);

      // LDI/ADD/lane-index store
      clear_init();
      add(enc(1, 1, 0, 0, 5)); add(enc(1, 2, 0, 0, 7));
      add(enc(2, 3, 1, 2, 0)); add(enc(2, 4, 3, 15, 0));
      add(enc(7, 0, 15, 4, 0)); add(enc(15, 0, 0, 0, 0));
      run_prog(1'b1);
      for (int i = 0; i < 4; i++) check("prog1_dmem", dmem[i], 16'(12 + i));

      // reset in the middle of the store sequence
      load_mems();
      @(negedge clk);
      reset = 1'b1;
      found = 0;
      for (int c = 0; c < 200 && found == 0; c++) begin
         @(negedge clk);
         if (bus.DataMemWrEn === 1'b1) found = 1;
      end
      check("midst_wren_seen", found, 1);
      #2 reset = 1'b0;
      #1;
      check("midst_wren", bus.DataMemWrEn, 0);
      check("midst_pc", bus.inst_addr, 0);
      check("midst_daddr", bus.DataAddress, 0);
      check("midst_wdata", bus.DataToWrite, 0);
      check("midst_state", dut.state, 0);
      repeat (2) @(posedge clk);

      // load / double / store
      clear_init();
      for (int i = 0; i < 4; i++) dmem_init[i] = 16'(i + 1);
      add(enc(6, 1, 15, 0, 0)); add(enc(2, 1, 1, 1, 0));
      add(enc(7, 0, 15, 1, 4)); add(enc(15, 0, 0, 0, 0));
      run_prog(1'b0);
      for (int i = 0; i < 4; i++) check("prog2_dmem", dmem[4 + i], 16'(2 * (i + 1)));

      // wraparound subtract and R0 write-ignore
      clear_init();
      add(enc(1, 1, 0, 0, 1)); add(enc(3, 2, 0, 1, 0));
      add(enc(7, 0, 15, 2, 8)); add(enc(1, 0, 0, 0, 9));
      add(enc(7, 0, 15, 0, 12)); add(enc(15, 0, 0, 0, 0));
      run_prog(1'b0);
      for (int i = 0; i < 4; i++) check("wrap_dmem", dmem[8 + i], 16'hFFFF);
      for (int i = 0; i < 4; i++) check("r0_dmem", dmem[12 + i], 16'h0);

      // all lanes store to one address; highest lane persists
      clear_init();
      add(enc(7, 0, 0, 15, 20)); add(enc(15, 0, 0, 0, 0));
      run_prog(1'b0);
      check("collision_dmem", dmem[20], 16'd3);
      check("collision_pulses", wr_pulses, 4);

      // opcode 9: MUL when enabled, NOP otherwise
      clear_init();
      add(enc(1, 1, 0, 0, 200)); add(enc(1, 2, 0, 0, 200));
      add(enc(9, 3, 1, 2, 0)); add(enc(7, 0, 15, 3, 40)); add(enc(15, 0, 0, 0, 0));
      run_prog(1'b0);
`ifdef SMCORE_MUL_EN
      check("mul_dmem", dmem[40], 16'h9C40);
`else
      check("op9_nop_dmem", dmem[40], 16'h0);
`endif

      // random programs against the model
      for (int t = 0; t < 15; t++) begin
         int n;
         plen = 0;
         for (int i = 0; i < 256; i++) dmem_init[i] = 16'($urandom);
         n = $urandom_range(3, 16);
         for (int i = 0; i < n; i++)
            add(enc(4'($urandom_range(0, 14)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 8'($urandom)));
         add(enc(15, 0, 0, 0, 0));
         run_prog(1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sm_core.md
Name: sm_core

Overview:
- Single-issue SIMT streaming-multiprocessor core. One scheduler fetches and decodes each instruction. N_LANES scalar lanes execute it in lockstep, each with a private register file and ALU.
- Talks to an external synchronous instruction memory and a single-port synchronous data memory, both with 1-cycle read latency.
- Lane memory accesses are serialized onto the one data port.

Parameters:
- N_LANES, 4, number of scalar lanes.
- DATA_W, 16, data word / register width.
- INST_W, 24, instruction width.
- IADDR_W, 8, instruction address width.
- DADDR_W, 8, data address width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- inst_addr  out  IADDR_W  instruction fetch address (PC).
- inst  in  INST_W  instruction word; valid one cycle after inst_addr is presented.
- DataAddress  out  DADDR_W  data memory address.
- DataToWrite  out  DATA_W  store data.
- DataToRead  in  DATA_W  load data; valid one cycle after DataAddress.
- DataMemWrEn  out  1  write enable; memory writes at the rising edge.

Behaviour:
- Instruction format: op[23:20], rd[19:16], ra[15:12], rb[11:8], imm[7:0] (imm zero-extended).
- Registers: 16 per lane, 16 bits each. R0 reads 0 and writes to it are ignored. R15 reads the lane index (0..N_LANES-1) and writes to it are ignored.
- Opcodes:
  - 0 NOP.
  - 1 LDI: rd=imm.
  - 2 ADD: rd=ra+rb.
  - 3 SUB: rd=ra-rb.
  - 4 AND.
  - 5 OR.
  - 6 LD: rd=M[ra+imm].
  - 7 ST: M[ra+imm]=rb.
  - 8 XOR.
  - F END.
  - Any other opcode executes as NOP.
- Arithmetic wraps modulo 2^DATA_W. Effective address = low DADDR_W bits of (ra+imm).
- The control unit is a 5-bit state register `state` with encodings: FETCH=0, DECODE=1, EXEC=2, MEM_ADDR=3, MEM_WAIT=4, END=19.
- FETCH -> DECODE:
  - inst_addr=PC.
- DECODE -> next state:
  - Latch inst.
  - END opcode -> END.
  - LD/ST -> MEM_ADDR with lane counter=0.
  - Otherwise -> EXEC.
- EXEC:
  - All lanes write rd simultaneously.
  - PC+1, wrapping 2^IADDR_W-1 -> 0.
  - -> FETCH.
  - ALU instructions take exactly 3 cycles.
- MEM_ADDR, for lane k:
  - Drive DataAddress.
  - ST: DataMemWrEn=1 and DataToWrite=rb of lane k for exactly one cycle. Then k+1, or PC+1 -> FETCH after the last lane.
  - LD: -> MEM_WAIT.
- MEM_WAIT:
  - Capture DataToRead into rd of lane k.
  - Then k+1 -> MEM_ADDR, or PC+1 -> FETCH after the last lane.
- Memory instruction cost: ST = 2+N_LANES cycles; LD = 2+2*N_LANES cycles.
- Stores are performed in ascending lane order, so on an address collision the highest lane's value persists.
- END is absorbing: PC frozen, DataMemWrEn=0, no register writes. Only reset leaves END.
- Reset asserted, including mid-instruction:
  - Immediately: PC=0, all registers 0, state=FETCH, DataMemWrEn=0, DataAddress=0, DataToWrite=0, inst_addr=0.
  - Any partially completed memory sequence is abandoned.
- DataMemWrEn is never high outside MEM_ADDR of a ST.

Optional Feature:
- SMCORE_MUL_EN defined: opcode 9 MUL, rd = low DATA_W bits of ra*rb, takes the 3-cycle EXEC path.
- Undefined: opcode 9 executes as NOP and no multiplier is synthesized.

Decomposition:
- Package smcore_pkg holds:
  - width constants;
  - opcode enum;
  - CU state enum with END=19;
  - instruction field slice helpers.
- One sub-module, sp_lane: register file plus ALU, with a parameter for its lane index. It is instantiated N_LANES times by generate.
- Companion behavioural models:
  - data_memory(clk, we, addr, wdata, rdata): registered read, write at the rising edge, 2^DADDR_W words, all zero at start.
  - instruction_memory(clk, addr, inst): registered read, loaded by $readmemh.

Test Plan:
- Reset: after reset release, inst_addr=0, DataMemWrEn=0, state=0. Assert reset mid-ST -> DataMemWrEn falls immediately and PC=0.
- Program "LDI R1,5; LDI R2,7; ADD R3,R1,R2; ADD R4,R3,R15; ST [R15+0]=R4; END" -> DMem[0..3]=12,13,14,15; state reaches 19.
- Preload DMem[0..3]=1,2,3,4. Program "LD R1,[R15+0]; ADD R1,R1,R1; ST [R15+4]=R1; END" -> DMem[4..7]=2,4,6,8.
- Wrap and R0: "LDI R1,1; SUB R2,R0,R1; ST [R15+8]=R2; LDI R0,9; ST [R15+12]=R0" -> DMem[8..11]=0xFFFF and DMem[12..15]=0.
- Collision: "ST [R0+20]=R15" -> DMem[20]=3, with exactly 4 write-enable pulses.
- END hold: 20 cycles after END -> state stays 19, inst_addr constant, DataMemWrEn=0. With SMCORE_MUL_EN, "LDI R1,300; LDI R2,300; MUL R3,R1,R2" cannot load 300 (imm is 8 bits), so the MUL check uses LDI 200/200 -> R3=0x9C40.
